prbs16_checker: RTL and testbench

Receive-side checker for the 16-bit XNOR LFSR stream produced by the PRNG datapath. It accepts one serial bit per qualified cycle and self-synchronises a local copy of the generator LFSR to the incoming stream. Once locked, it flywheels that LFSR and counts bit errors. It sits at the far end of a loopback or board link so the generator can be checked bit-exactly on silicon.

---
 rtl/prbs16_checker_if.sv | 21 ++
 rtl/prbs16_checker.sv | 141 ++++++++++++++
 tb/tb_prbs16_checker.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs16_checker_if.sv
// Bundles the serial input stream, counter clear and checker status outputs.
interface prbs16_checker_if;
  logic        in_valid;
  logic        in_bit;
  logic        clear_cnt;
  logic [1:0]  state;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output in_valid, in_bit, clear_cnt,
    input  state, locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  in_valid, in_bit, clear_cnt,
    output state, locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream
// (next = ~(r[15]^r[14]^r[12]^r[3])). Hunts for a fill, verifies a run of
// correct predictions, then flywheels its own LFSR and counts bit errors.
module prbs16_checker #(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input logic             clk,
  input logic             reset,
  prbs16_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_COUNT);
  localparam logic [7:0]  WIN_LAST  = 8'(WINDOW - 1);
  localparam logic [8:0]  LOSS_LIM  = 9'(LOSS_THRESH);
  localparam logic [15:0] LOCKUP    = 16'hFFFF;
  localparam logic [4:0]  FILL_FULL = 5'd16;

  state_t      st;
  logic [15:0] r;
  logic [4:0]  fill;
  logic [7:0]  match_cnt;
  logic [7:0]  win_cnt;
  logic [8:0]  win_err;
  logic        locked_q;
  logic        err_pulse_q;
  logic [15:0] err_count_q;
  logic [31:0] bit_count_q;

  logic        pred;
  logic        mismatch;
  logic [15:0] r_rx;
  logic [15:0] r_fly;
  logic [7:0]  match_inc;
  logic [8:0]  win_err_inc;
  logic        fill_done;

  // Prediction and candidate next LFSR values for the current sample.
  always_comb begin
    pred        = ~(r[15] ^ r[14] ^ r[12] ^ r[3]);
    mismatch    = bus.in_bit ^ pred;
    r_rx        = {r[14:0], bus.in_bit};
    r_fly       = {r[14:0], pred};
    match_inc   = match_cnt + 8'd1;
    win_err_inc = win_err + {8'd0, mismatch};
    fill_done   = (fill >= 5'd15);
  end

  // Sync state machine, window tracking and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= HUNT;
      r           <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.clear_cnt) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end
      if (bus.in_valid) begin
        case (st)
          HUNT: begin
            r    <= r_rx;
            fill <= fill_done ? FILL_FULL : fill + 5'd1;
            if (fill_done && r_rx != LOCKUP) begin
              st        <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            r <= r_rx;
            if (r_rx == LOCKUP) begin
              st   <= HUNT;
              fill <= FILL_FULL;
            end else if (!mismatch) begin
              match_cnt <= match_inc;
              if (match_inc == LOCK_LAST) begin
                st       <= LOCKED;
                locked_q <= 1'b1;
                win_cnt  <= '0;
                win_err  <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            r <= r_fly;
            if (!bus.clear_cnt && bit_count_q != '1)
              bit_count_q <= bit_count_q + 32'd1;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (!bus.clear_cnt && err_count_q != '1)
                err_count_q <= err_count_q + 16'd1;
            end
            // The wrap sample is scored into the closing window before reset.
            if (win_err_inc >= LOSS_LIM) begin
              st       <= HUNT;
              locked_q <= 1'b0;
              fill     <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 8'd1;
              win_err <= win_err_inc;
            end
          end
          default: begin
            st       <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state     = st;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: directed streams from a reference generator,
// a recurrence-based reference model checked every cycle, plus literal pins.
module tb_prbs16_checker;

  localparam int LOCK_N = 32;
  localparam int WIN_N  = 64;
  localparam int THR_N  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  prbs16_checker_if ifc();

  prbs16_checker #(
    .LOCK_COUNT (LOCK_N),
    .WINDOW     (WIN_N),
    .LOSS_THRESH(THR_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_en = 1'b0;

  logic [15:0] g;

  // Reference model: mode 0/1/2, history of the last 16 sequence bits.
  int     m_mode, m_fill, m_match, m_win, m_werr, m_ec;
  bit     m_pulse;
  longint m_bc;
  bit     hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit gen_next();
    logic nb;
    nb = ~(g[15] ^ g[14] ^ g[12] ^ g[3]);
    g = {g[14:0], nb};
    return nb;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_ec = 0; m_bc = 0; m_pulse = 1'b0;
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
  endfunction

  function automatic bit model_pred();
    return !(hist[0] ^ hist[1] ^ hist[3] ^ hist[12]);
  endfunction

  function automatic bit model_all_ones();
    int ones = 0;
    foreach (hist[i]) ones += int'(hist[i]);
    return ones == 16;
  endfunction

  function automatic void model_push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  function automatic void model_update(input bit v, input bit b, input bit clr, input bit rst);
    bit p;
    if (rst) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    if (clr) begin
      m_ec = 0;
      m_bc = 0;
    end
    if (!v) return;
    if (m_mode == 0) begin
      model_push(b);
      if (m_fill < 16) m_fill++;
      if (m_fill == 16 && !model_all_ones()) begin
        m_mode = 1;
        m_match = 0;
      end
    end else if (m_mode == 1) begin
      p = model_pred();
      model_push(b);
      if (model_all_ones()) begin
        m_mode = 0;
        m_fill = 16;
      end else if (b == p) begin
        m_match++;
        if (m_match == LOCK_N) begin
          m_mode = 2; m_win = 0; m_werr = 0;
        end
      end else begin
        m_match = 0;
      end
    end else begin
      p = model_pred();
      model_push(p);
      if (!clr && m_bc < 64'hFFFF_FFFF) m_bc++;
      if (b != p) begin
        m_pulse = 1'b1;
        if (!clr && m_ec < 65535) m_ec++;
        m_werr++;
      end
      if (m_werr >= THR_N) begin
        m_mode = 0; m_fill = 0; m_win = 0; m_werr = 0;
      end else begin
        m_win++;
        if (m_win == WIN_N) begin
          m_win = 0;
          m_werr = 0;
        end
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     64'(ifc.state),     64'(m_mode));
      chk("locked",    64'(ifc.locked),    64'(m_mode == 2));
      chk("err_pulse", 64'(ifc.err_pulse), 64'(m_pulse));
      chk("err_count", 64'(ifc.err_count), 64'(m_ec));
      chk("bit_count", 64'(ifc.bit_count), 64'(m_bc));
    end
  end

  task automatic step(input bit v, input bit b, input bit clr, input bit rst);
    ifc.in_valid  = v;
    ifc.in_bit    = b;
    ifc.clear_cnt = clr;
    reset         = rst;
    @(posedge clk);
    model_update(v, b, clr, rst);
    @(negedge clk);
  endtask

  task automatic relock();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'h0000;
    repeat (48) step(1'b1, gen_next(), 1'b0, 1'b0);
    chk("relock_locked", 64'(ifc.locked), 64'd1);
  endtask

  initial begin
    logic [4:0] first5;
    bit b;
    bit e;
    int w;
    int o;

    ifc.in_valid  = 1'b0;
    ifc.in_bit    = 1'b0;
    ifc.clear_cnt = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // Reset with in_valid high.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_state",     64'(ifc.state),     64'd0);
    chk("rst_locked",    64'(ifc.locked),    64'd0);
    chk("rst_err_count", 64'(ifc.err_count), 64'd0);
    chk("rst_bit_count", 64'(ifc.bit_count), 64'd0);
    chk("rst_err_pulse", 64'(ifc.err_pulse), 64'd0);

    // Clean lock from seed 0.
    g = 16'h0000;
    first5 = '0;
    for (int i = 1; i <= 100; i++) begin
      b = gen_next();
      if (i <= 5) first5 = {first5[3:0], b};
      step(1'b1, b, 1'b0, 1'b0);
      if (i == 4)  chk("gen_after4", 64'(g), 64'h000F);
      if (i == 5)  chk("gen_after5", 64'(g), 64'h001E);
      if (i == 5)  chk("gen_first5", 64'(first5), 64'h1E);
      if (i == 15) chk("hunt_bit15", 64'(ifc.state), 64'd0);
      if (i == 16) chk("verify_bit16", 64'(ifc.state), 64'd1);
      if (i == 47) chk("unlocked_bit47", 64'(ifc.locked), 64'd0);
      if (i == 48) chk("locked_bit48", 64'(ifc.locked), 64'd1);
    end
    chk("clean_bit_count", 64'(ifc.bit_count), 64'd52);
    chk("clean_err_count", 64'(ifc.err_count), 64'd0);

    // Single error while locked.
    b = gen_next();
    step(1'b1, ~b, 1'b0, 1'b0);
    chk("single_pulse", 64'(ifc.err_pulse), 64'd1);
    chk("single_count", 64'(ifc.err_count), 64'd1);
    step(1'b1, gen_next(), 1'b0, 1'b0);
    chk("single_pulse_drop", 64'(ifc.err_pulse), 64'd0);
    repeat (199) step(1'b1, gen_next(), 1'b0, 1'b0);
    chk("single_after_count", 64'(ifc.err_count), 64'd1);
    chk("single_after_locked", 64'(ifc.locked), 64'd1);

    // Loss of lock: 8 errors inside one window.
    relock();
    for (int i = 0; i < 16; i++) begin
      b = gen_next();
      step(1'b1, b ^ (i % 2 == 0), 1'b0, 1'b0);
      if (i == 12) chk("loss_7th_locked", 64'(ifc.locked), 64'd1);
    end
    chk("loss_locked", 64'(ifc.locked), 64'd0);
    chk("loss_state", 64'(ifc.state), 64'd0);
    chk("loss_err_count", 64'(ifc.err_count), 64'd8);

    // Loss where the 8th error is the window's wrap sample.
    relock();
    for (int i = 0; i < 64; i++) begin
      b = gen_next();
      step(1'b1, b ^ (i >= 56), 1'b0, 1'b0);
      if (i == 62) chk("wrap_loss_pre", 64'(ifc.locked), 64'd1);
    end
    chk("wrap_loss_locked", 64'(ifc.locked), 64'd0);
    chk("wrap_loss_err_count", 64'(ifc.err_count), 64'd8);

    // Seven errors per window over three windows stays locked.
    relock();
    for (int i = 0; i < 192; i++) begin
      w = i / 64;
      o = i % 64;
      e = (w == 0 && o >= 57) || (w == 1 && o < 7) || (w == 2 && o >= 30 && o < 37);
      b = gen_next();
      step(1'b1, b ^ e, 1'b0, 1'b0);
    end
    chk("seven_locked", 64'(ifc.locked), 64'd1);
    chk("seven_err_count", 64'(ifc.err_count), 64'd21);

    // Lock-up rejection then clean stream.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("lockup_state", 64'(ifc.state), 64'd0);
    end
    g = 16'h0000;
    repeat (48) step(1'b1, gen_next(), 1'b0, 1'b0);
    chk("lockup_relock", 64'(ifc.locked), 64'd1);

    // clear_cnt coincident with an error.
    relock();
    repeat (3) step(1'b1, gen_next(), 1'b0, 1'b0);
    b = gen_next();
    step(1'b1, ~b, 1'b1, 1'b0);
    chk("clr_err_count", 64'(ifc.err_count), 64'd0);
    chk("clr_err_pulse", 64'(ifc.err_pulse), 64'd1);
    chk("clr_bit_count", 64'(ifc.bit_count), 64'd0);
    chk("clr_locked", 64'(ifc.locked), 64'd1);

    // in_valid toggling every other cycle.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g = 16'h0000;
    for (int c = 1; c <= 96; c++) begin
      if (c % 2 == 1) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else            step(1'b1, gen_next(), 1'b0, 1'b0);
      if (c == 95) chk("toggle_unlocked95", 64'(ifc.locked), 64'd0);
      if (c == 96) chk("toggle_locked96", 64'(ifc.locked), 64'd1);
    end

    // Reset while locked, right after an error.
    b = gen_next();
    step(1'b1, ~b, 1'b0, 1'b0);
    chk("pre_rst_pulse", 64'(ifc.err_pulse), 64'd1);
    step(1'b1, gen_next(), 1'b0, 1'b1);
    chk("midrst_state",     64'(ifc.state),     64'd0);
    chk("midrst_locked",    64'(ifc.locked),    64'd0);
    chk("midrst_err_pulse", 64'(ifc.err_pulse), 64'd0);
    chk("midrst_err_count", 64'(ifc.err_count), 64'd0);
    chk("midrst_bit_count", 64'(ifc.bit_count), 64'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
